sdfa_sram_loader: RTL and testbench

Write-side engine for the 256x(256x14) weight SRAM. It accepts a valid/ready stream of 14-bit weights and packs every 8 consecutive weights into one bank chunk. It then issues single-bank writes (one-hot WE, ADDR_WRITE, DIN) row by row until the requested number of rows is filled. It sits between the host/DMA weight stream and the SRAM write port; the datapath's read side (EN_M/ADDR/DOUT) is untouched.

---
 rtl/sdfa_pkg.sv | 21 ++
 rtl/sdfa_chunk_packer.sv | 38 +++
 rtl/sdfa_sram_loader.sv | 153 +++++++++++++++
 tb/tb_sdfa_sram_loader.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdfa_pkg.sv
// Shared parameters and types for the SDFA weight-SRAM write path.
// Weight/bank/row geometry, derived chunk and row widths, loader state.
package sdfa_pkg;

    localparam int W_SIZE_BIT       = 14;
    localparam int WEIGHTS_PER_BANK = 8;
    localparam int NUM_BANKS        = 32;
    localparam int NEURON_SIZE_BIT  = 8;

    localparam int CHUNK_W  = W_SIZE_BIT * WEIGHTS_PER_BANK;
    localparam int ROW_W    = NUM_BANKS * CHUNK_W;
    localparam int BANK_BIT = $clog2(NUM_BANKS);
    localparam int WCNT_BIT = $clog2(WEIGHTS_PER_BANK);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FINISH
    } loader_state_t;

endpackage

// File: rtl/sdfa_chunk_packer.sv
// Packs consecutive weights into one bank chunk, first weight in MSBs.
// Ports: clk, rst (async high), clear, beat, data in; chunk, chunk_valid out.
module sdfa_chunk_packer
    import sdfa_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  beat,
    input  logic [W_SIZE_BIT-1:0] data,
    output logic [CHUNK_W-1:0]    chunk,
    output logic                  chunk_valid
);

    localparam logic [WCNT_BIT-1:0] LAST = WCNT_BIT'(WEIGHTS_PER_BANK - 1);

    logic [WCNT_BIT-1:0]           cnt;
    logic [CHUNK_W-W_SIZE_BIT-1:0] shreg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            shreg <= '0;
        end else if (clear) begin
            cnt   <= '0;
            shreg <= '0;
        end else if (beat) begin
            cnt   <= (cnt == LAST) ? '0 : cnt + 1'b1;
            shreg <= {shreg[CHUNK_W-2*W_SIZE_BIT-1:0], data};
        end
    end

    // The final weight bypasses the register so the chunk is
    // available in the same cycle as its last beat.
    assign chunk       = {shreg, data};
    assign chunk_valid = beat && (cnt == LAST) && !clear;

endmodule

// File: rtl/sdfa_sram_loader.sv
// Write-side loader for the weight SRAM: streams weights, writes one bank per chunk.
// Ports: CLK, RST (async high), START/START_ROW/ROW_COUNT, ABORT, S_VALID/S_READY/S_DATA,
//        WE (one-hot), ADDR_WRITE, DIN, BUSY, DONE, CHECKSUM.
// Option: define SDFA_LOADER_CHECKSUM_EN to build the running weight checksum.
module sdfa_sram_loader
    import sdfa_pkg::*;
(
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       START,
    input  logic [NEURON_SIZE_BIT-1:0] START_ROW,
    input  logic [NEURON_SIZE_BIT:0]   ROW_COUNT,
    input  logic                       ABORT,
    input  logic                       S_VALID,
    output logic                       S_READY,
    input  logic [W_SIZE_BIT-1:0]      S_DATA,
    output logic [NUM_BANKS-1:0]       WE,
    output logic [NEURON_SIZE_BIT-1:0] ADDR_WRITE,
    output logic [ROW_W-1:0]           DIN,
    output logic                       BUSY,
    output logic                       DONE,
    output logic [15:0]                CHECKSUM
);

    localparam logic [BANK_BIT-1:0] LAST_BANK = BANK_BIT'(NUM_BANKS - 1);

    loader_state_t state, state_nxt;

    logic [NEURON_SIZE_BIT-1:0] row_q;
    logic [NEURON_SIZE_BIT:0]   rem_q;
    logic [BANK_BIT-1:0]        bank_q;

    logic [NUM_BANKS-1:0]       we_q;
    logic [NEURON_SIZE_BIT-1:0] addr_q;
    logic [ROW_W-1:0]           din_q;
    logic [ROW_W-1:0]           din_nxt;
    logic                       zdone_q;

    logic                 beat;
    logic                 start_go;
    logic                 start_zero;
    logic                 wr;
    logic                 last_chunk;
    logic [CHUNK_W-1:0]   chunk;
    logic                 chunk_valid;

    assign beat       = S_VALID && (state == ST_LOAD);
    assign start_go   = (state == ST_IDLE) && START && !ABORT
                        && (ROW_COUNT != '0);
    assign start_zero = (state == ST_IDLE) && START && !ABORT
                        && (ROW_COUNT == '0);

    sdfa_chunk_packer u_packer (
        .clk         (CLK),
        .rst         (RST),
        .clear       (ABORT || start_go),
        .beat        (beat),
        .data        (S_DATA),
        .chunk       (chunk),
        .chunk_valid (chunk_valid)
    );

    assign wr         = chunk_valid && !ABORT;
    assign last_chunk = wr && (bank_q == LAST_BANK) && (rem_q == 1);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:   if (start_go) state_nxt = ST_LOAD;
            ST_LOAD:   if (last_chunk) state_nxt = ST_FINISH;
            ST_FINISH: state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
        if (ABORT) state_nxt = ST_IDLE;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            row_q  <= '0;
            rem_q  <= '0;
            bank_q <= '0;
        end else if (start_go) begin
            row_q  <= START_ROW;
            rem_q  <= ROW_COUNT;
            bank_q <= '0;
        end else if (wr) begin
            if (bank_q == LAST_BANK) begin
                bank_q <= '0;
                row_q  <= row_q + 1'b1;
                rem_q  <= rem_q - 1'b1;
            end else begin
                bank_q <= bank_q + 1'b1;
            end
        end
    end

    // Bank 0 occupies the most significant chunk of the row.
    always_comb begin
        din_nxt = '0;
        din_nxt[(NUM_BANKS-1-int'(bank_q))*CHUNK_W +: CHUNK_W] = chunk;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            we_q    <= '0;
            addr_q  <= '0;
            din_q   <= '0;
            zdone_q <= 1'b0;
        end else begin
            we_q    <= '0;
            zdone_q <= start_zero;
            if (wr) begin
                we_q   <= NUM_BANKS'(1) << bank_q;
                addr_q <= row_q;
                din_q  <= din_nxt;
            end
        end
    end

    assign WE         = we_q;
    assign ADDR_WRITE = addr_q;
    assign DIN        = din_q;
    assign S_READY    = (state == ST_LOAD);
    assign BUSY       = (state != ST_IDLE);
    assign DONE       = (state == ST_FINISH) || zdone_q;

`ifdef SDFA_LOADER_CHECKSUM_EN
    logic [15:0] csum_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            csum_q <= '0;
        end else if (start_go) begin
            csum_q <= '0;
        end else if (beat) begin
            csum_q <= csum_q + 16'(S_DATA);
        end
    end

    assign CHECKSUM = csum_q;
`else
    assign CHECKSUM = '0;
`endif

endmodule

// File: tb/tb_sdfa_sram_loader.sv
// Self-checking bench for sdfa_sram_loader against a write-list model.
// Honors SDFA_LOADER_CHECKSUM_EN for the CHECKSUM expectation.
module tb_sdfa_sram_loader;
    import sdfa_pkg::*;

    logic                       CLK;
    logic                       RST;
    logic                       START;
    logic [NEURON_SIZE_BIT-1:0] START_ROW;
    logic [NEURON_SIZE_BIT:0]   ROW_COUNT;
    logic                       ABORT;
    logic                       S_VALID;
    logic                       S_READY;
    logic [W_SIZE_BIT-1:0]      S_DATA;
    logic [NUM_BANKS-1:0]       WE;
    logic [NEURON_SIZE_BIT-1:0] ADDR_WRITE;
    logic [ROW_W-1:0]           DIN;
    logic                       BUSY;
    logic                       DONE;
    logic [15:0]                CHECKSUM;

    sdfa_sram_loader dut (
        .CLK        (CLK),
        .RST        (RST),
        .START      (START),
        .START_ROW  (START_ROW),
        .ROW_COUNT  (ROW_COUNT),
        .ABORT      (ABORT),
        .S_VALID    (S_VALID),
        .S_READY    (S_READY),
        .S_DATA     (S_DATA),
        .WE         (WE),
        .ADDR_WRITE (ADDR_WRITE),
        .DIN        (DIN),
        .BUSY       (BUSY),
        .DONE       (DONE),
        .CHECKSUM   (CHECKSUM)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_cmp;
    int n_bad;

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Monitor: log every write and control event at the falling edge.
    int                         cyc;
    logic [NUM_BANKS-1:0]       wr_we[$];
    logic [NEURON_SIZE_BIT-1:0] wr_addr[$];
    logic [ROW_W-1:0]           wr_din[$];
    int                         wr_cyc[$];
    int                         done_cnt;
    int                         done_cyc;
    int                         busy_cnt;
    int                         last_busy;
    int                         ready_bad;

    initial cyc = 0;

    always @(negedge CLK) begin
        if (WE != '0) begin
            wr_we.push_back(WE);
            wr_addr.push_back(ADDR_WRITE);
            wr_din.push_back(DIN);
            wr_cyc.push_back(cyc);
        end
        if (DONE) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (BUSY) begin
            busy_cnt++;
            last_busy = cyc;
        end
        if (S_READY !== (BUSY && !DONE)) ready_bad++;
        cyc++;
    end

    task automatic clear_mon();
        wr_we.delete();
        wr_addr.delete();
        wr_din.delete();
        wr_cyc.delete();
        done_cnt  = 0;
        done_cyc  = -1;
        busy_cnt  = 0;
        last_busy = -1;
        ready_bad = 0;
    endtask

    // vmode: 0 continuous, 1 every other cycle, 2 random valid.
    // kill:  0 none, 1 ABORT, 2 RST, applied once kill_beat beats are in.
    // dmode: 0 weights 0,1,2..., 1 random weights.
    task automatic run_load(input int srow, input int rcnt, input int vmode,
                            input int kill, input int kill_beat,
                            input int dmode, input bit glitch);
        logic [W_SIZE_BIT-1:0] w[$];
        logic [CHUNK_W-1:0]    ch;
        logic [15:0]           sum;
        int total, idx, it, nw, bank, row, nz, bad_gap, gap;
        bit acc, killed;

        clear_mon();
        total = rcnt * 256;
        for (int i = 0; i < total; i++)
            w.push_back(dmode == 0 ? W_SIZE_BIT'(i) : W_SIZE_BIT'($urandom));

        @(posedge CLK); #1;
        START     = 1'b1;
        START_ROW = NEURON_SIZE_BIT'(srow);
        ROW_COUNT = (NEURON_SIZE_BIT+1)'(rcnt);
        S_VALID   = 1'b0;
        @(posedge CLK); #1;
        START = 1'b0;

        idx = 0;
        it = 0;
        killed = 0;
        while (!killed && idx < total && it < total * 4 + 50) begin
            if (kill != 0 && idx == kill_beat) begin
                killed = 1;
                S_VALID = 1'b0;
                if (kill == 1) begin
                    ABORT = 1'b1;
                    @(posedge CLK); #1;
                    ABORT = 1'b0;
                    @(negedge CLK);
                    check("busy_after_abort", BUSY, 0);
                    check("ready_after_abort", S_READY, 0);
                end else begin
                    RST = 1'b1;
                    #2;
                    check("rst_we", WE, 0);
                    check("rst_addr", ADDR_WRITE, 0);
                    check("rst_din_nz", DIN != '0, 0);
                    check("rst_ctl", {BUSY, DONE, S_READY}, 0);
                    check("rst_csum", CHECKSUM, 0);
                    @(posedge CLK); #1;
                    RST = 1'b0;
                end
            end else begin
                case (vmode)
                    0: S_VALID = 1'b1;
                    1: S_VALID = (it % 2 == 0);
                    default: S_VALID = 1'($urandom_range(0, 1));
                endcase
                S_DATA = w[idx];
                START  = glitch && (it == 40);
                if (glitch && it == 40) begin
                    START_ROW = NEURON_SIZE_BIT'(srow + 7);
                    ROW_COUNT = 5;
                end
                @(negedge CLK);
                if (it == 0) begin
                    check("busy_after_start", BUSY, 1);
                    check("ready_after_start", S_READY, 1);
                end
                acc = S_VALID && S_READY;
                @(posedge CLK); #1;
                if (acc) idx++;
                it++;
            end
        end
        S_VALID = 1'b0;
        START   = 1'b0;
        if (!killed && idx < total) check("timeout_beats", idx, total);

        repeat (4) @(posedge CLK);
        #1;

        nw = idx / WEIGHTS_PER_BANK;
        check("n_writes", wr_we.size(), nw);
        bad_gap = 0;
        for (int k = 0; k < nw && k < wr_we.size(); k++) begin
            bank = k % NUM_BANKS;
            row  = (srow + k / NUM_BANKS) % 256;
            ch = '0;
            for (int j = 0; j < WEIGHTS_PER_BANK; j++)
                ch = (ch << W_SIZE_BIT) | CHUNK_W'(w[k*WEIGHTS_PER_BANK+j]);
            check("we", wr_we[k], 128'(1) << bank);
            check("addr", wr_addr[k], row);
            check("din_slice",
                  wr_din[k][(NUM_BANKS-1-bank)*CHUNK_W +: CHUNK_W], ch);
            nz = 0;
            for (int b = 0; b < NUM_BANKS; b++)
                if (b != bank && wr_din[k][(NUM_BANKS-1-b)*CHUNK_W +: CHUNK_W] != '0)
                    nz++;
            check("din_other_zero", nz, 0);
            if (k > 0 && vmode < 2) begin
                gap = wr_cyc[k] - wr_cyc[k-1];
                if (gap != (vmode == 0 ? 8 : 16)) bad_gap++;
            end
        end
        check("write_spacing", bad_gap, 0);
        check("ready_rule", ready_bad, 0);

        if (kill == 0) begin
            check("done_count", done_cnt, 1);
            if (wr_cyc.size() > 0)
                check("done_with_last_we", done_cyc, wr_cyc[wr_cyc.size()-1]);
            check("busy_falls_after_done", last_busy, done_cyc);
            sum = '0;
            for (int i = 0; i < idx; i++) sum = sum + 16'(w[i]);
`ifdef SDFA_LOADER_CHECKSUM_EN
            check("checksum", CHECKSUM, sum);
`else
            check("checksum_tied", CHECKSUM, 0);
`endif
        end else begin
            check("no_done_after_kill", done_cnt, 0);
        end
    endtask

    int t0;

    initial begin
        n_cmp = 0;
        n_bad = 0;
        RST = 1'b1;
        START = 1'b0;
        START_ROW = '0;
        ROW_COUNT = '0;
        ABORT = 1'b0;
        S_VALID = 1'b0;
        S_DATA = '0;
        clear_mon();

        repeat (2) @(posedge CLK);
        #1;
        check("reset_we", WE, 0);
        check("reset_addr", ADDR_WRITE, 0);
        check("reset_din_nz", DIN != '0, 0);
        check("reset_ctl", {BUSY, DONE, S_READY}, 0);
        check("reset_csum", CHECKSUM, 0);
        RST = 1'b0;

        run_load(0, 1, 0, 0, 0, 0, 0);
        if (wr_din.size() >= 32) begin
            check("bank0_msb_weight", wr_din[0][ROW_W-1 -: W_SIZE_BIT], 0);
            check("bank31_lsb_weight", wr_din[31][W_SIZE_BIT-1:0], 255);
        end

        run_load(255, 2, 0, 0, 0, 1, 1);
        if (wr_addr.size() > 32) begin
            check("wrap_first_row", wr_addr[0], 255);
            check("wrap_second_row", wr_addr[32], 0);
        end

        run_load(0, 1, 1, 0, 0, 0, 0);

        run_load(10, 1, 0, 1, 3 * WEIGHTS_PER_BANK + 5, 1, 0);

        clear_mon();
        @(posedge CLK); #1;
        START = 1'b1;
        ROW_COUNT = '0;
        t0 = cyc;
        @(posedge CLK); #1;
        START = 1'b0;
        repeat (4) @(posedge CLK);
        #1;
        check("zero_done_count", done_cnt, 1);
        check("zero_done_cycle", done_cyc, t0 + 1);
        check("zero_no_write", wr_we.size(), 0);
        check("zero_no_busy", busy_cnt, 0);

        run_load(3, 1, 0, 2, 100, 1, 0);

        run_load($urandom_range(0, 255), $urandom_range(1, 3), 2, 0, 0, 1, 0);
        run_load($urandom_range(200, 255), $urandom_range(1, 3), 2, 0, 0, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
